weight_bank_stream: RTL

- Runtime-loadable weight store for one fully-connected layer. It holds NUM_NEURON banks of NUM_WEIGHT signed fixed-point weights each.
- Weights are loaded once through a streaming valid/ready port. On each start pulse the block replays all banks in lockstep, one weight index per beat, to the layer's MAC array.
- It is the parametrised successor of the per-neuron constant weight ROMs. Each instance now serves a whole layer, and weights are writable at runtime.

---
 rtl/weight_bank_stream.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/weight_bank_stream.sv
// Runtime-loadable weight store for one fully-connected layer: NUM_NEURON banks are
// loaded neuron-major through a valid/ready port, then replayed in lockstep per start.
module weight_bank_stream #(
  parameter int NUM_WEIGHT = 30,
  parameter int NUM_NEURON = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT),
  parameter int NEUR_WIDTH = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [DATA_WIDTH-1:0]            load_data,
  output logic                             load_done,
  output logic                             loaded,
  input  logic                             start,
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_NEURON*DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]            out_idx,
  output logic                             out_last,
  output logic                             stream_done
);

  localparam logic [ADDR_WIDTH-1:0] K_MAX = ADDR_WIDTH'(NUM_WEIGHT - 1);
  localparam logic [NEUR_WIDTH-1:0] B_MAX = NEUR_WIDTH'(NUM_NEURON - 1);

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  wptr_reg;
  logic [NEUR_WIDTH-1:0]  bptr_reg;
  logic                   loaded_reg;
  logic                   load_done_reg;
  logic [ADDR_WIDTH-1:0]  k_reg;
  logic                   issued_all_reg;
  logic                   out_valid_reg;
  logic [ADDR_WIDTH-1:0]  out_idx_reg;
  logic                   out_last_reg;
  logic                   stream_done_reg;

  logic advance;
  logic issue;
  logic load_accept;
  logic start_accept;
  logic last_accept;

  // start wins over a same-cycle load beat; reset also holds the port closed
  assign load_ready = (state_reg == IDLE) && !start && !rst;

  always_comb begin
    state_next   = state_reg;
    load_accept  = 1'b0;
    start_accept = 1'b0;
    issue        = 1'b0;
    last_accept  = 1'b0;
    advance      = !out_valid_reg || out_ready;
    case (state_reg)
      IDLE: begin
        load_accept = load_valid && load_ready;
        if (start && loaded_reg && (wptr_reg == '0) && (bptr_reg == '0)) begin
          start_accept = 1'b1;
          state_next   = STREAM;
        end
      end
      STREAM: begin
        issue       = advance && !issued_all_reg;
        last_accept = out_valid_reg && out_ready && out_last_reg;
        if (last_accept) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      wptr_reg        <= '0;
      bptr_reg        <= '0;
      loaded_reg      <= 1'b0;
      load_done_reg   <= 1'b0;
      k_reg           <= '0;
      issued_all_reg  <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_idx_reg     <= '0;
      out_last_reg    <= 1'b0;
      stream_done_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      load_done_reg   <= 1'b0;
      stream_done_reg <= last_accept;

      if (load_accept) begin
        // a fresh load invalidates the old set until the final beat lands
        if ((wptr_reg == '0) && (bptr_reg == '0)) begin
          loaded_reg <= 1'b0;
        end
        if (wptr_reg == K_MAX) begin
          wptr_reg <= '0;
          if (bptr_reg == B_MAX) begin
            bptr_reg      <= '0;
            loaded_reg    <= 1'b1;
            load_done_reg <= 1'b1;
          end else begin
            bptr_reg <= bptr_reg + 1'b1;
          end
        end else begin
          wptr_reg <= wptr_reg + 1'b1;
        end
      end

      if (start_accept) begin
        k_reg          <= '0;
        issued_all_reg <= 1'b0;
      end

      if ((state_reg == STREAM) && advance) begin
        out_valid_reg <= issue;
        if (issue) begin
          out_idx_reg  <= k_reg;
          out_last_reg <= (k_reg == K_MAX);
          if (k_reg == K_MAX) begin
            issued_all_reg <= 1'b1;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
      end
    end
  end

  // One block RAM per bank; its read register doubles as the output data register
  for (genvar gi = 0; gi < NUM_NEURON; gi++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [NUM_WEIGHT];
    logic [DATA_WIDTH-1:0] rd_reg;

    always_ff @(posedge clk) begin
      if (load_accept && (bptr_reg == NEUR_WIDTH'(gi))) begin
        mem[wptr_reg] <= load_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_reg <= '0;
      end else if (issue) begin
        rd_reg <= mem[k_reg];
      end
    end

    assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd_reg;
  end

  assign busy        = (state_reg == STREAM);
  assign loaded      = loaded_reg;
  assign load_done   = load_done_reg;
  assign out_valid   = out_valid_reg;
  assign out_idx     = out_idx_reg;
  assign out_last    = out_last_reg;
  assign stream_done = stream_done_reg;

endmodule
